// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core: execution-sequencer state encoding
// and the legal range of the instruction ROM read latency.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_EXEC  = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } seq_state_t;

  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 7;
  localparam int WAIT_CNT_W  = 3;

endpackage

// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: walks each instruction through fetch, ROM wait,
// latch, execute and writeback, gating PC/register-file updates to once per instruction.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int ROM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             wreg,
  input  logic             is_jmp,
  output logic             rom_en,
  output logic             inst_ld,
  output logic             reg_we,
  output logic             pc_en,
  output logic             pc_sel_jmp,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  if (ROM_LAT < ROM_LAT_MIN || ROM_LAT > ROM_LAT_MAX) begin : g_rom_lat_check
    $error("exec_sequencer: ROM_LAT=%0d outside legal range 1..7", ROM_LAT);
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(ROM_LAT - 1);

  seq_state_t            cur_state;
  seq_state_t            nxt_state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
  logic                  single;
  logic                  single_nxt;
  logic                  halt_pending;
  logic                  halt_pending_nxt;
  logic                  retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state    <= S_IDLE;
      wait_cnt     <= '0;
      single       <= 1'b0;
      halt_pending <= 1'b0;
      retired      <= '0;
    end else begin
      cur_state    <= nxt_state;
      wait_cnt     <= wait_cnt_nxt;
      single       <= single_nxt;
      halt_pending <= halt_pending_nxt;
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign busy   = (cur_state == S_FETCH) || (cur_state == S_WAIT) ||
                  (cur_state == S_LOAD)  || (cur_state == S_EXEC) ||
                  (cur_state == S_WB);
  assign halted = (cur_state == S_HALT);
  assign state  = cur_state;

  always_comb begin
    nxt_state        = cur_state;
    wait_cnt_nxt     = wait_cnt;
    single_nxt       = single;
    halt_pending_nxt = halt_pending;
    retire           = 1'b0;
    rom_en           = 1'b0;
    inst_ld          = 1'b0;
    reg_we           = 1'b0;
    pc_en            = 1'b0;
    pc_sel_jmp       = 1'b0;

    case (cur_state)
      S_IDLE: begin
        if (halt_req) begin
          nxt_state = S_HALT;
        end else if (run) begin
          nxt_state = S_FETCH;
        end else if (step) begin
          nxt_state  = S_FETCH;
          single_nxt = 1'b1;
        end
      end
      S_FETCH: begin
        rom_en       = 1'b1;
        wait_cnt_nxt = WAIT_INIT;
        nxt_state    = (ROM_LAT == 1) ? S_LOAD : S_WAIT;
      end
      S_WAIT: begin
        // Counter holds the ROM cycles still outstanding; the last one overlaps LOAD's edge.
        if (wait_cnt <= WAIT_CNT_W'(1)) begin
          nxt_state = S_LOAD;
        end else begin
          wait_cnt_nxt = wait_cnt - WAIT_CNT_W'(1);
        end
      end
      S_LOAD: begin
        inst_ld   = 1'b1;
        nxt_state = S_EXEC;
      end
      S_EXEC: begin
        nxt_state = S_WB;
      end
      S_WB: begin
        pc_en      = 1'b1;
        pc_sel_jmp = is_jmp;
        reg_we     = wreg;
        retire     = 1'b1;
        if (halt_pending || halt_req) begin
          nxt_state = S_HALT;
        end else if (single || !run) begin
          nxt_state  = S_IDLE;
          single_nxt = 1'b0;
        end else begin
          nxt_state = S_FETCH;
        end
      end
      S_HALT: begin
        if (!halt_req) begin
          nxt_state = S_IDLE;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase

    // A halt request seen at any point of an instruction is remembered until HALT is reached.
    if (busy && halt_req) begin
      halt_pending_nxt = 1'b1;
    end
    if (nxt_state == S_HALT) begin
      halt_pending_nxt = 1'b0;
    end
  end

endmodule
